// File: rtl/timer_contador.sv
// Cooking-time countdown: MM:SS BCD entry from the keypad, one-second decrements while m_on is high, tdone at 00:00.
// Optional QUICK_START_EN: key code 4'hA loads 00:30 while idle.
module timer_contador #(
    parameter int DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       limpan,
    input  logic       m_on,
    output logic [3:0] min_dez,
    output logic [3:0] min_uni,
    output logic [3:0] seg_dez,
    output logic [3:0] seg_uni,
    output logic       tdone,
    output logic       contando
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {VAZIO, PROGRAMADO, CONTANDO, FIM} state_t;

    // state is kept as a named signal so checkers can bind to it directly
    state_t          state, state_nx;
    logic [PW-1:0]   psc, psc_nx;
    logic [15:0]     tm, tm_nx;
    logic [15:0]     tm_dec, tm_shift;
    logic [3:0]      dec0, dec1, dec2, dec3;
    logic            b0, b1, b2;
    logic            key_ok, quick;

    assign {min_dez, min_uni, seg_dez, seg_uni} = tm;

    // One-second BCD decrement; seconds tens borrow from 0 to 5, other digits to 9
    always_comb begin
        b0   = (tm[3:0] == 4'd0);
        dec0 = b0 ? 4'd9 : tm[3:0] - 4'd1;
        b1   = b0 && (tm[7:4] == 4'd0);
        dec1 = b0 ? ((tm[7:4] == 4'd0) ? 4'd5 : tm[7:4] - 4'd1) : tm[7:4];
        b2   = b1 && (tm[11:8] == 4'd0);
        dec2 = b1 ? ((tm[11:8] == 4'd0) ? 4'd9 : tm[11:8] - 4'd1) : tm[11:8];
        dec3 = b2 ? tm[15:12] - 4'd1 : tm[15:12];
        tm_dec = {dec3, dec2, dec1, dec0};
    end

    // FIM always shows 00:00, so shifting from a zero base matches the display
    assign tm_shift = (state == FIM) ? {12'h000, key_digit} : {tm[11:0], key_digit};
    assign key_ok   = key_valid && !m_on && (state != CONTANDO) && (key_digit <= 4'd9);

`ifdef QUICK_START_EN
    assign quick = key_valid && !m_on && (state != CONTANDO) && (key_digit == 4'hA);
`else
    assign quick = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        tm_nx    = tm;
        psc_nx   = psc;
        if (!limpan) begin
            state_nx = VAZIO;
            tm_nx    = 16'h0000;
            psc_nx   = '0;
        end else begin
            case (state)
                CONTANDO: begin
                    if (!m_on) begin
                        state_nx = PROGRAMADO;
                        psc_nx   = '0;
                    end else if (psc == PW'(DIV - 1)) begin
                        psc_nx = '0;
                        tm_nx  = tm_dec;
                        if (tm_dec == 16'h0000) state_nx = FIM;
                    end else begin
                        psc_nx = psc + 1'b1;
                    end
                end
                PROGRAMADO: begin
                    if (m_on) begin
                        state_nx = CONTANDO;
                        psc_nx   = '0;
                    end else if (quick) begin
                        tm_nx    = 16'h0030;
                        state_nx = PROGRAMADO;
                    end else if (key_ok) begin
                        tm_nx    = tm_shift;
                        state_nx = (tm_shift != 16'h0000) ? PROGRAMADO : VAZIO;
                    end
                end
                default: begin
                    if (quick) begin
                        tm_nx    = 16'h0030;
                        state_nx = PROGRAMADO;
                    end else if (key_ok) begin
                        tm_nx    = tm_shift;
                        state_nx = (tm_shift != 16'h0000) ? PROGRAMADO : VAZIO;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= VAZIO;
            tm       <= 16'h0000;
            psc      <= '0;
            tdone    <= 1'b0;
            contando <= 1'b0;
        end else begin
            state    <= state_nx;
            tm       <= tm_nx;
            psc      <= psc_nx;
            tdone    <= (state_nx == FIM);
            contando <= (state_nx == CONTANDO);
        end
    end

endmodule

// File: tb/tb_timer_contador.sv
// Bench for timer_contador with DIV=4: table of single-cycle vectors plus countdown, pause, borrow and reset sequences.
module tb_timer_contador;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       limpan = 1'b1;
    logic       m_on = 1'b0;
    logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
    logic       tdone, contando;

    int n_checks = 0;
    int n_errors = 0;
    logic [17:0] exp_q[$];

    timer_contador #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
        .limpan(limpan), .m_on(m_on), .min_dez(min_dez), .min_uni(min_uni),
        .seg_dez(seg_dez), .seg_uni(seg_uni), .tdone(tdone), .contando(contando)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        kv;
        logic [3:0]  kd;
        logic        lim;
        logic        mon;
        logic [17:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[13];

    // Expected record: {min_dez, min_uni, seg_dez, seg_uni, tdone, contando}
    function automatic logic [17:0] ex(int mm, int ss, bit t, bit c);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), t, c};
    endfunction

    task automatic compare(string name);
        logic [17:0] e, a;
        e = exp_q.pop_front();
        a = {min_dez, min_uni, seg_dez, seg_uni, tdone, contando};
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %h%h:%h%h tdone=%b contando=%b, want %h%h:%h%h tdone=%b contando=%b",
                     name, a[17:14], a[13:10], a[9:6], a[5:2], a[1], a[0],
                     e[17:14], e[13:10], e[9:6], e[5:2], e[1], e[0]);
        end
    endtask

    task automatic step(logic kv, logic [3:0] kd, logic lim, logic mon, logic [17:0] e, string name);
        @(negedge clk);
        key_valid = kv;
        key_digit = kd;
        limpan    = lim;
        m_on      = mon;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare(name);
    endtask

    task automatic steps(int n, logic mon, logic [17:0] e, string name);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b1, mon, e, name);
    endtask

    task automatic key(logic [3:0] d, logic [17:0] e, string name);
        step(1'b1, d, 1'b1, 1'b0, e, name);
    endtask

    task automatic clear();
        step(1'b0, 4'd0, 1'b0, 1'b0, ex(0, 0, 0, 0), "clear");
    endtask

    initial begin
        logic [17:0] quick_exp;
`ifdef QUICK_START_EN
        quick_exp = ex(0, 30, 0, 0);
`else
        quick_exp = ex(0, 0, 0, 0);
`endif
        vecs[0]  = '{1'b1, 4'd1, 1'b1, 1'b0, ex(0, 1, 0, 0),  "entry_1"};
        vecs[1]  = '{1'b1, 4'd3, 1'b1, 1'b0, ex(0, 13, 0, 0), "entry_3"};
        vecs[2]  = '{1'b1, 4'd0, 1'b1, 1'b0, ex(1, 30, 0, 0), "entry_0"};
        vecs[3]  = '{1'b1, 4'hF, 1'b1, 1'b0, ex(1, 30, 0, 0), "key_F_ignored"};
        vecs[4]  = '{1'b0, 4'd5, 1'b1, 1'b0, ex(1, 30, 0, 0), "no_strobe"};
        vecs[5]  = '{1'b1, 4'd7, 1'b0, 1'b0, ex(0, 0, 0, 0),  "clear_beats_key"};
        vecs[6]  = '{1'b1, 4'd0, 1'b1, 1'b0, ex(0, 0, 0, 0),  "zero_key_vazio"};
        vecs[7]  = '{1'b0, 4'd0, 1'b1, 1'b1, ex(0, 0, 0, 0),  "vazio_m_on"};
        vecs[8]  = '{1'b1, 4'd5, 1'b1, 1'b1, ex(0, 0, 0, 0),  "key_with_m_on"};
        vecs[9]  = '{1'b1, 4'd2, 1'b1, 1'b0, ex(0, 2, 0, 0),  "entry_2"};
        vecs[10] = '{1'b1, 4'hA, 1'b1, 1'b0, ex(0, 2, 0, 0),  "key_A_prog_placeholder"};
        vecs[11] = '{1'b0, 4'd0, 1'b0, 1'b0, ex(0, 0, 0, 0),  "clear_level"};
        vecs[12] = '{1'b1, 4'hA, 1'b1, 1'b0, quick_exp,       "key_A_vazio"};
`ifdef QUICK_START_EN
        vecs[10].exp = ex(0, 30, 0, 0);
`endif

        // Reset state, checked while rst_n is still asserted
        #12;
        exp_q.push_back(ex(0, 0, 0, 0));
        compare("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            step(vecs[i].kv, vecs[i].kd, vecs[i].lim, vecs[i].mon, vecs[i].exp, vecs[i].name);

        // Countdown 00:02 to FIM
        clear();
        key(4'd0, ex(0, 0, 0, 0), "cd_key0");
        key(4'd2, ex(0, 2, 0, 0), "cd_key2");
        steps(1, 1'b1, ex(0, 2, 0, 1), "cd_enter");
        steps(3, 1'b1, ex(0, 2, 0, 1), "cd_wait1");
        steps(1, 1'b1, ex(0, 1, 0, 1), "cd_tick1");
        steps(3, 1'b1, ex(0, 1, 0, 1), "cd_wait2");
        steps(1, 1'b1, ex(0, 0, 1, 0), "cd_done");
        steps(1, 1'b0, ex(0, 0, 1, 0), "fim_holds");
        step(1'b1, 4'd7, 1'b1, 1'b1, ex(0, 0, 1, 0), "fim_key_m_on");
        key(4'd7, ex(0, 7, 0, 0), "fim_key_accepted");

        // Pause with a partial second pending, then resume from a fresh prescaler
        steps(1, 1'b1, ex(0, 7, 0, 1), "p_enter");
        steps(3, 1'b1, ex(0, 7, 0, 1), "p_wait");
        steps(1, 1'b1, ex(0, 6, 0, 1), "p_tick1");
        step(1'b1, 4'd3, 1'b1, 1'b1, ex(0, 6, 0, 1), "p_key_ignored");
        steps(2, 1'b1, ex(0, 6, 0, 1), "p_wait2");
        steps(1, 1'b1, ex(0, 5, 0, 1), "p_tick2");
        steps(2, 1'b1, ex(0, 5, 0, 1), "p_partial");
        steps(1, 1'b0, ex(0, 5, 0, 0), "p_pause");
        steps(1, 1'b1, ex(0, 5, 0, 1), "p_resume");
        steps(3, 1'b1, ex(0, 5, 0, 1), "p_resume_wait");
        steps(1, 1'b1, ex(0, 4, 0, 1), "p_resume_tick");

        // Asynchronous reset in the middle of a count
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_on  = 1'b0;
        #1;
        exp_q.push_back(ex(0, 0, 0, 0));
        compare("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Borrow chain 10:00 -> 09:59
        key(4'd1, ex(0, 1, 0, 0), "b_key1");
        key(4'd0, ex(0, 10, 0, 0), "b_key0a");
        key(4'd0, ex(1, 0, 0, 0), "b_key0b");
        key(4'd0, ex(10, 0, 0, 0), "b_key0c");
        steps(4, 1'b1, ex(10, 0, 0, 1), "b_count");
        steps(1, 1'b1, ex(9, 59, 0, 1), "b_borrow");
        steps(1, 1'b0, ex(9, 59, 0, 0), "b_pause");

        // Unnormalised seconds 00:90 -> 00:89
        clear();
        key(4'd9, ex(0, 9, 0, 0), "u_key9");
        key(4'd0, ex(0, 90, 0, 0), "u_key0");
        steps(4, 1'b1, ex(0, 90, 0, 1), "u_count");
        steps(1, 1'b1, ex(0, 89, 0, 1), "u_tick");
        steps(1, 1'b0, ex(0, 89, 0, 0), "u_pause");

        // Maximum value 99:99
        clear();
        key(4'd9, ex(0, 9, 0, 0), "m_key1");
        key(4'd9, ex(0, 99, 0, 0), "m_key2");
        key(4'd9, ex(9, 99, 0, 0), "m_key3");
        key(4'd9, ex(99, 99, 0, 0), "m_key4");
        steps(4, 1'b1, ex(99, 99, 0, 1), "m_count");
        steps(1, 1'b1, ex(99, 98, 0, 1), "m_tick");
        clear();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so a stuck run still reports
    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
